// File: rtl/twos_complement_seq.sv
// Multi-cycle two's-complement unit: pass / negate / absolute value on a WIDTH-bit
// operand, CHUNK bits per cycle, with valid/ready handshakes on both sides.
module twos_complement_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH < 2) || (WIDTH % CHUNK != 0)) begin : g_bad_params
        $error("twos_complement_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_inv;
    logic [WIDTH-1:0]   r_data;
    logic               r_ovf;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;

    logic               w_accept;
    logic               w_inv;
    logic               w_last;
    logic [CHUNK-1:0]   w_chunk_in;
    logic [CHUNK:0]     w_sum;
    logic [CHUNK-1:0]   w_chunk_out;

    assign w_accept    = in_valid && in_ready;
    // Abs of a non-negative operand degenerates to pass; everything else inverts and adds.
    assign w_inv       = !((in_mode == 2'b00) || ((in_mode == 2'b10) && !in_data[WIDTH-1]));
    assign w_last      = (r_idx == IDX_W'(N - 1));
    assign w_chunk_in  = r_opnd[r_idx*CHUNK +: CHUNK];
    assign w_sum       = {1'b0, ~w_chunk_in} + {{CHUNK{1'b0}}, r_carry};
    assign w_chunk_out = r_inv ? w_sum[CHUNK-1:0] : w_chunk_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_next = S_BUSY;
            S_BUSY:  if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        out_data  = r_data;
        out_ovf   = r_ovf;
    end

    // Operand and op are only consumed while BUSY, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_opnd <= in_data;
            r_inv  <= w_inv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b1;
            r_data  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx   <= '0;
                        r_carry <= 1'b1;
                        r_ovf   <= w_inv && (in_data == {1'b1, {(WIDTH-1){1'b0}}});
                    end
                end
                S_BUSY: begin
                    r_data[r_idx*CHUNK +: CHUNK] <= w_chunk_out;
                    r_carry                      <= w_sum[CHUNK];
                    r_idx                        <= w_last ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_twos_complement_seq.sv
// Randomized and directed bench for twos_complement_seq at W8/C4, W16/C1 and W16/C16.
module tb_twos_complement_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v8 = 1'b0, or8 = 1'b0, rdy8, ov8, of8;
    logic [7:0]  d8 = '0, od8;
    logic [1:0]  m8 = '0;

    logic        iv16 = 1'b0, or16 = 1'b0, rdyA, ovA, ofA, rdyB, ovB, ofB;
    logic [15:0] id16 = '0, odA, odB;
    logic [1:0]  im16 = '0;

    int n_vec = 0;
    int n_err = 0;

    twos_complement_seq #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_data(d8), .in_mode(m8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_ovf(of8));
    twos_complement_seq #(.WIDTH(16), .CHUNK(1)) dut16a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdyA), .in_data(id16), .in_mode(im16),
        .out_valid(ovA), .out_ready(or16), .out_data(odA), .out_ovf(ofA));
    twos_complement_seq #(.WIDTH(16), .CHUNK(16)) dut16b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdyB), .in_data(id16), .in_mode(im16),
        .out_valid(ovB), .out_ready(or16), .out_data(odB), .out_ovf(ofB));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: interpret the operand as a signed integer and apply the mode arithmetically.
    task automatic ref_model(input int w, input logic [31:0] x, input logic [1:0] m,
                             output logic [31:0] r, output logic o);
        longint span, ux, sx, v;
        bit neg;
        span = 64'sd1 <<< w;
        ux   = longint'(x);
        sx   = (ux >= span / 2) ? ux - span : ux;
        neg  = (m == 2'b01) || (m == 2'b11) || ((m == 2'b10) && (sx < 0));
        v    = neg ? -sx : sx;
        v    = ((v % span) + span) % span;
        r    = v[31:0];
        o    = neg && (sx == -(span / 2));
    endtask

    task automatic run8(input logic [7:0] d, input logic [1:0] m, input int stall);
        logic [31:0] er;
        logic        eo;
        int          cyc;
        ref_model(8, {24'd0, d}, m, er, eo);
        @(negedge clk);
        chk("w8 in_ready idle", rdy8, 1);
        v8 = 1'b1; d8 = d; m8 = m; or8 = 1'b0;
        @(negedge clk);
        v8 = 1'b0; d8 = 8'($urandom); m8 = 2'($urandom);
        cyc = 0;
        while (!ov8 && cyc < 100) begin
            or8 = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        or8 = 1'b0;
        chk("w8 latency", cyc, 2);
        chk("w8 out_valid", ov8, 1);
        chk("w8 out_data", od8, er);
        chk("w8 out_ovf", of8, eo);
        chk("w8 in_ready done", rdy8, 0);
        for (int i = 0; i < stall; i++) begin
            v8 = 1'($urandom); d8 = 8'($urandom);
            @(negedge clk);
            chk("w8 stall valid", ov8, 1);
            chk("w8 stall data", od8, er);
            chk("w8 stall ovf", of8, eo);
            chk("w8 stall in_ready", rdy8, 0);
        end
        v8 = 1'b0; or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        chk("w8 valid drop", ov8, 0);
        chk("w8 ready back", rdy8, 1);
    endtask

    task automatic run16(input logic [15:0] d, input logic [1:0] m);
        logic [31:0] er;
        logic        eo;
        int          cyc, la, lb;
        ref_model(16, {16'd0, d}, m, er, eo);
        @(negedge clk);
        chk("w16 c1 in_ready", rdyA, 1);
        chk("w16 c16 in_ready", rdyB, 1);
        iv16 = 1'b1; id16 = d; im16 = m; or16 = 1'b0;
        @(negedge clk);
        iv16 = 1'b0; id16 = 16'($urandom);
        cyc = 0; la = -1; lb = -1;
        while ((la < 0 || lb < 0) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ovA && la < 0) la = cyc;
            if (ovB && lb < 0) lb = cyc;
        end
        chk("w16 c1 latency", la, 16);
        chk("w16 c16 latency", lb, 1);
        chk("w16 c1 data", odA, er);
        chk("w16 c1 ovf", ofA, eo);
        chk("w16 c16 data", odB, er);
        chk("w16 c16 ovf", ofB, eo);
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
        chk("w16 c1 valid drop", ovA, 0);
        chk("w16 c16 valid drop", ovB, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst out_valid", ov8, 0);
        chk("rst out_data", od8, 0);
        chk("rst out_ovf", of8, 0);
        chk("rst in_ready", rdy8, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready", rdy8, 1);

        run8(8'h05, 2'b01, 0);
        chk("neg 05 value", od8, 8'hFB);
        run8(8'h80, 2'b01, 0);
        chk("neg 80 ovf", of8, 1);
        run8(8'h80, 2'b10, 0);
        chk("abs 80 value", od8, 8'h80);
        run8(8'hF0, 2'b10, 0);
        chk("abs F0 value", od8, 8'h10);
        run8(8'h10, 2'b10, 0);
        run8(8'hA5, 2'b00, 0);
        chk("pass A5 value", od8, 8'hA5);
        run8(8'h00, 2'b01, 0);
        run8(8'h05, 2'b11, 0);
        run8(8'h7F, 2'b01, 5);

        // Reset while BUSY: the first chunk has already been written.
        @(negedge clk);
        v8 = 1'b1; d8 = 8'h55; m8 = 2'b01;
        @(negedge clk);
        v8 = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-busy rst valid", ov8, 0);
        chk("mid-busy rst data", od8, 0);
        chk("mid-busy rst ovf", of8, 0);
        chk("mid-busy rst in_ready", rdy8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'h01, 2'b01, 0);
        chk("post-rst neg 01", od8, 8'hFF);

        for (int i = 0; i < 1000; i++)
            run8(8'($urandom), 2'($urandom), int'($urandom_range(0, 3)));

        run16(16'h0001, 2'b01);
        chk("w16 neg 0001", odA, 16'hFFFF);
        run16(16'h8000, 2'b10);
        run16(16'h1234, 2'b00);
        for (int i = 0; i < 20; i++)
            run16(16'($urandom), 2'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
